// File: rtl/output_drain_streamer.sv
// output_drain_streamer
//
// Reads rows out of a bank of NUM_BRAMS accumulation BRAMs and streams them as
// AXI-Stream beats. Each row is read with one shared address, captured into a
// row buffer, and sent one lane per beat, lane 0 first.
//
// Optional feature: define DRAIN_RELU_EN to clamp negative captured samples to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num_words    begin a drain of num_words rows (sampled in idle only)
//   busy, done          drain in progress / single-cycle completion pulse
//   ext_read_mode       selects external read port of the accumulation BRAMs
//   ext_read_addr_flat  row address replicated in every lane field
//   ext_read_data_flat  lane data, valid one cycle after the address
//   m_axis_*            AXI-Stream master (tdata, tvalid, tready, tlast)
module output_drain_streamer #(
  parameter int unsigned DW        = 16,
  parameter int unsigned NUM_BRAMS = 16,
  parameter int unsigned O_ADDR_W  = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [O_ADDR_W:0]             num_words,
  output logic                          busy,
  output logic                          done,
  output logic                          ext_read_mode,
  output logic [NUM_BRAMS*O_ADDR_W-1:0] ext_read_addr_flat,
  input  logic [NUM_BRAMS*DW-1:0]       ext_read_data_flat,
  output logic [DW-1:0]                 m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  localparam int unsigned LaneW = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_BRAMS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Row counter and length are one bit wider than the address so that a full
  // 2^O_ADDR_W-row drain terminates without wrapping.
  logic [O_ADDR_W:0] num_words_q, num_words_d;
  logic [O_ADDR_W:0] row_q, row_d;
  logic [LaneW-1:0]  lane_q, lane_d;
  logic [DW-1:0]     row_buf_q [NUM_BRAMS];

  logic beat_fire;
  logic last_lane;
  logic last_row;

  assign beat_fire = (state_q == StSend) && m_axis_tready;
  assign last_lane = (lane_q == LastLane);
  assign last_row  = ((row_q + 1'b1) == num_words_q);

  // State and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      num_words_q <= '0;
      row_q       <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      num_words_q <= num_words_d;
      row_q       <= row_d;
      lane_q      <= lane_d;
    end
  end

  // Row buffer: all lanes are captured at the end of the wait cycle, when the
  // BRAM data for the address presented in the read cycle is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < int'(NUM_BRAMS); l++) begin
        row_buf_q[l] <= '0;
      end
    end else if (state_q == StWait) begin
      for (int l = 0; l < int'(NUM_BRAMS); l++) begin
`ifdef DRAIN_RELU_EN
        row_buf_q[l] <= ext_read_data_flat[l*DW + DW - 1] ? '0 : ext_read_data_flat[l*DW +: DW];
`else
        row_buf_q[l] <= ext_read_data_flat[l*DW +: DW];
`endif
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    num_words_d = num_words_q;
    row_d       = row_q;
    lane_d      = lane_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_words_d = num_words;
          row_d       = '0;
          lane_d      = '0;
          state_d     = (num_words == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        state_d = StWait;
      end
      StWait: begin
        lane_d  = '0;
        state_d = StSend;
      end
      StSend: begin
        if (beat_fire) begin
          if (last_lane) begin
            lane_d = '0;
            if (last_row) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = StRead;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from the state register so that an asynchronous
  // reset clears them in the same cycle.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    ext_read_mode = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;

    unique case (state_q)
      StRead, StWait: begin
        busy          = 1'b1;
        ext_read_mode = 1'b1;
      end
      StSend: begin
        busy          = 1'b1;
        ext_read_mode = 1'b1;
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = row_buf_q[lane_q];
        m_axis_tlast  = last_lane && last_row;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Address is forced to zero whenever the external read port is deselected.
  always_comb begin
    ext_read_addr_flat = '0;
    if (ext_read_mode) begin
      for (int l = 0; l < int'(NUM_BRAMS); l++) begin
        ext_read_addr_flat[l*O_ADDR_W +: O_ADDR_W] = row_q[O_ADDR_W-1:0];
      end
    end
  end

endmodule
